// File: rtl/mir_pkg.sv
// Shared definitions for the MIR core program-counter path.
//   PC_W / N_PROC / PROC_W : address width, context count, context-id width
//   OS_PROC_ID             : context id of the operating system
//   OS_ENTRY / BOOT_ADDR   : preemption vector and post-reset pc
//   pc_t / proc_id_t       : address and context-id types
//   pc_inc()               : wrapping pc+1
package mir_pkg;

    localparam int PC_W   = 10;
    localparam int N_PROC = 4;   // power of two; context 0 is the OS
    localparam int PROC_W = $clog2(N_PROC);

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [PROC_W-1:0] proc_id_t;

    localparam proc_id_t OS_PROC_ID = '0;
    localparam pc_t      OS_ENTRY   = '0;
    localparam pc_t      BOOT_ADDR  = '0;

    // Address arithmetic wraps modulo 2^PC_W by construction of pc_t.
    function automatic pc_t pc_inc(input pc_t p);
        return p + pc_t'(1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> pc_sequencer bundle.
//   master : control unit side (drives decode flags and operands)
//   slave  : pc_sequencer side (drives pc, pc_link, cur_proc, os_mode, preempt)
interface pc_sequencer_if;
    import mir_pkg::*;

    logic        hlt;
    logic        branch;
    logic        branch_cond;
    logic        jMUX;
    logic        jrMUX;
    logic        jal;
    logic        proc_swap;
    logic        change_proc_pc;
    logic        save_proc_pc;
    pc_t         imm_target;
    logic [31:0] reg_data;
    proc_id_t    proc_sel;

    pc_t         pc;
    pc_t         pc_link;
    proc_id_t    cur_proc;
    logic        os_mode;
    logic        preempt;

    modport master (
        output hlt, branch, branch_cond, jMUX, jrMUX, jal, proc_swap,
               change_proc_pc, save_proc_pc, imm_target, reg_data, proc_sel,
        input  pc, pc_link, cur_proc, os_mode, preempt
    );

    modport slave (
        input  hlt, branch, branch_cond, jMUX, jrMUX, jal, proc_swap,
               change_proc_pc, save_proc_pc, imm_target, reg_data, proc_sel,
        output pc, pc_link, cur_proc, os_mode, preempt
    );

endinterface

// File: rtl/pc_sequencer_proc_pc_table.sv
// proc_pc_table: saved-PC register file, one entry per process context.
//   clk, reset              : clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_addr/wr_data   : single synchronous write port
//   rd_sel_addr/rd_sel_data : async read port for the swap target
//   rd_cur_addr/rd_cur_data : async read port for the running context
// Reads are combinational from the registers, so a write lands one cycle
// after it is issued and a same-cycle read sees the old contents.
module proc_pc_table
    import mir_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     wr_en,
    input  proc_id_t wr_addr,
    input  pc_t      wr_data,
    input  proc_id_t rd_sel_addr,
    output pc_t      rd_sel_data,
    input  proc_id_t rd_cur_addr,
    output pc_t      rd_cur_data
);

    pc_t entry_reg [N_PROC];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PROC; i++) begin
            if (reset) begin
                entry_reg[i] <= '0;
            end else if (wr_en && (wr_addr == proc_id_t'(i))) begin
                entry_reg[i] <= wr_data;
            end
        end
    end

    assign rd_sel_data = entry_reg[rd_sel_addr];
    assign rd_cur_data = entry_reg[rd_cur_addr];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, process-context switching and the
// round-robin preemption timer for the MIR single-cycle core.
//   clk     : clock
//   reset   : synchronous active-high reset
//   bus     : pc_sequencer_if.slave (decode flags in; pc, pc_link,
//             cur_proc, os_mode, preempt out)
//   QUANTUM : executed user instructions per time slice (>= 2)
module pc_sequencer
    import mir_pkg::*;
#(
    parameter int QUANTUM = 64
)(
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    pc_t              pc_reg, pc_next;
    proc_id_t         proc_reg, proc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             preempt_reg, preempt_next;
    logic             os_mode_reg;

    pc_t              seq_pc;
    logic             exec, in_user, expire;

    logic             tbl_wr_en;
    proc_id_t         tbl_wr_addr;
    pc_t              tbl_wr_data;
    pc_t              tbl_sel_pc;
    pc_t              tbl_cur_pc;

    assign exec    = ~bus.hlt;
    assign in_user = (proc_reg != OS_PROC_ID);
    // A swap on the last slice cycle takes precedence and cancels the expiry.
    assign expire  = exec && in_user && (cnt_reg == CNT_LAST) && !bus.proc_swap;

    // Address the running instruction hands on when no context change happens.
    always_comb begin
        seq_pc = pc_inc(pc_reg);
        if (bus.jrMUX) begin
            seq_pc = bus.reg_data[PC_W-1:0];
        end else if (bus.jMUX) begin
            seq_pc = bus.imm_target;
        end else if (bus.branch && bus.branch_cond) begin
            seq_pc = bus.imm_target;
        end
    end

    // pc / context / timer next state; hlt holds everything.
    always_comb begin
        pc_next      = pc_reg;
        proc_next    = proc_reg;
        cnt_next     = cnt_reg;
        preempt_next = expire;
        if (exec) begin
            if (bus.proc_swap) begin
                pc_next   = tbl_sel_pc;
                proc_next = bus.proc_sel;
                cnt_next  = '0;
            end else if (expire) begin
                pc_next   = OS_ENTRY;
                proc_next = OS_PROC_ID;
                cnt_next  = '0;
            end else begin
                pc_next  = seq_pc;
                cnt_next = in_user ? (cnt_reg + CNT_W'(1)) : '0;
            end
        end
    end

    // Single table write port: the preemption save outranks the explicit
    // write requests, since the interrupted context must not lose its pc.
    always_comb begin
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = proc_reg;
        tbl_wr_data = seq_pc;
        if (expire) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = proc_reg;
            tbl_wr_data = seq_pc;
        end else if (exec && bus.change_proc_pc) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = bus.proc_sel;
            tbl_wr_data = bus.reg_data[PC_W-1:0];
        end else if (exec && bus.save_proc_pc) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = proc_reg;
            tbl_wr_data = pc_inc(pc_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg      <= BOOT_ADDR;
            proc_reg    <= OS_PROC_ID;
            cnt_reg     <= '0;
            preempt_reg <= 1'b0;
            os_mode_reg <= 1'b1;
        end else begin
            pc_reg      <= pc_next;
            proc_reg    <= proc_next;
            cnt_reg     <= cnt_next;
            preempt_reg <= preempt_next;
            os_mode_reg <= (proc_next == OS_PROC_ID);
        end
    end

    proc_pc_table u_table (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (tbl_wr_en),
        .wr_addr     (tbl_wr_addr),
        .wr_data     (tbl_wr_data),
        .rd_sel_addr (bus.proc_sel),
        .rd_sel_data (tbl_sel_pc),
        .rd_cur_addr (proc_reg),
        .rd_cur_data (tbl_cur_pc)
    );

    // The running context's saved pc, the upper operand bits and jal carry
    // no information for the sequencer itself (pc_link is always valid).
    logic unused_bits;
    assign unused_bits = ^{tbl_cur_pc, bus.reg_data[31:PC_W], bus.jal};

    assign bus.pc       = pc_reg;
    assign bus.pc_link  = pc_inc(pc_reg);
    assign bus.cur_proc = proc_reg;
    assign bus.os_mode  = os_mode_reg;
    assign bus.preempt  = preempt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import mir_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(.QUANTUM(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic clear_flags();
        bus.hlt = 1'b0;            bus.branch = 1'b0;       bus.branch_cond = 1'b0;
        bus.jMUX = 1'b0;           bus.jrMUX = 1'b0;        bus.jal = 1'b0;
        bus.proc_swap = 1'b0;      bus.change_proc_pc = 1'b0;
        bus.save_proc_pc = 1'b0;   bus.imm_target = '0;
        bus.reg_data = '0;         bus.proc_sel = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: pc=%h cur_proc=%0d os_mode=%b preempt=%b",
                 cyc, bus.pc, bus.cur_proc, bus.os_mode, bus.preempt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_flags();
        step();
        step();
        vectors++;
        if (bus.pc !== BOOT_ADDR || bus.pc_link !== pc_t'(1)) begin
            miscompares++;
            $display("FAIL reset_pc: pc=%h pc_link=%h expected %h %h", bus.pc, bus.pc_link, BOOT_ADDR, pc_t'(1));
        end
        vectors++;
        if (bus.cur_proc !== proc_id_t'(0) || bus.os_mode !== 1'b1 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctx: cur=%0d os=%b pre=%b expected 0 1 0", bus.cur_proc, bus.os_mode, bus.preempt);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.pc !== pc_t'(i) || bus.pc_link !== pc_t'(i + 1)) begin
                miscompares++;
                $display("FAIL seq_%0d: pc=%h pc_link=%h expected %h %h", i, bus.pc, bus.pc_link, pc_t'(i), pc_t'(i + 1));
            end
            step();
        end
        // pc is now 5
        bus.branch = 1'b1; bus.branch_cond = 1'b0; bus.imm_target = pc_t'(10'h020);
        step();
        vectors++;
        if (bus.pc !== pc_t'(6)) begin
            miscompares++;
            $display("FAIL branch_not_taken: pc=%h expected %h", bus.pc, pc_t'(6));
        end
        bus.branch_cond = 1'b1;
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h020)) begin
            miscompares++;
            $display("FAIL branch_taken: pc=%h expected %h", bus.pc, pc_t'(10'h020));
        end
        clear_flags();
    endtask

    task automatic test_jump_priority();
        bus.jrMUX = 1'b1; bus.jMUX = 1'b1;
        bus.reg_data = 32'hABCD_E155; bus.imm_target = pc_t'(10'h010);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h155)) begin
            miscompares++;
            $display("FAIL jr_over_j: pc=%h expected %h", bus.pc, pc_t'(10'h155));
        end
        clear_flags();
        bus.jMUX = 1'b1; bus.imm_target = pc_t'(10'h3FF);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h3FF)) begin
            miscompares++;
            $display("FAIL jump_abs: pc=%h expected %h", bus.pc, pc_t'(10'h3FF));
        end
        clear_flags();
        bus.jal = 1'b1;
        #1;
        vectors++;
        if (bus.pc_link !== pc_t'(0)) begin
            miscompares++;
            $display("FAIL link_wrap: pc_link=%h expected %h", bus.pc_link, pc_t'(0));
        end
        clear_flags();
        step();
        vectors++;
        if (bus.pc !== pc_t'(0)) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%h expected %h", bus.pc, pc_t'(0));
        end
    endtask

    task automatic test_context_swap();
        bus.change_proc_pc = 1'b1; bus.proc_sel = proc_id_t'(2); bus.reg_data = 32'h0000_0080;
        step();
        clear_flags();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(2);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h080) || bus.cur_proc !== proc_id_t'(2) || bus.os_mode !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_p2: pc=%h cur=%0d os=%b expected 080 2 0", bus.pc, bus.cur_proc, bus.os_mode);
        end
        // write and swap to the same entry in one cycle: old value loads
        clear_flags();
        bus.change_proc_pc = 1'b1; bus.proc_swap = 1'b1;
        bus.proc_sel = proc_id_t'(1); bus.reg_data = 32'h0000_0044;
        step();
        vectors++;
        if (bus.pc !== pc_t'(0) || bus.cur_proc !== proc_id_t'(1)) begin
            miscompares++;
            $display("FAIL swap_same_cycle: pc=%h cur=%0d expected 000 1", bus.pc, bus.cur_proc);
        end
        clear_flags();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(1);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h044)) begin
            miscompares++;
            $display("FAIL swap_after_write: pc=%h expected %h", bus.pc, pc_t'(10'h044));
        end
        bus.proc_sel = proc_id_t'(0);
        step();
        vectors++;
        if (bus.pc !== pc_t'(0) || bus.cur_proc !== proc_id_t'(0) || bus.os_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_to_os: pc=%h cur=%0d os=%b expected 000 0 1", bus.pc, bus.cur_proc, bus.os_mode);
        end
        clear_flags();
    endtask

    task automatic test_preempt_hlt();
        pc_t exp_pc;
        int  pulses;
        pulses = 0;
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(2);
        step();
        clear_flags();
        exp_pc = pc_t'(10'h080);
        for (int e = 1; e <= 64; e++) begin
            if (e % 6 == 0) begin
                // halted cycle with other flags active: nothing may move
                bus.hlt = 1'b1; bus.proc_swap = 1'b1; bus.jMUX = 1'b1;
                step();
                if (bus.preempt === 1'b1) pulses++;
                vectors++;
                if (bus.pc !== exp_pc || bus.cur_proc !== proc_id_t'(2) || bus.preempt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hlt_hold_%0d: pc=%h cur=%0d pre=%b expected %h 2 0", e, bus.pc, bus.cur_proc, bus.preempt, exp_pc);
                end
                clear_flags();
            end
            if (e == 64) begin
                bus.jMUX = 1'b1; bus.imm_target = pc_t'(10'h1A0);
            end
            step();
            if (bus.preempt === 1'b1) pulses++;
            if (e < 64) begin
                exp_pc = exp_pc + pc_t'(1);
                vectors++;
                if (bus.pc !== exp_pc || bus.cur_proc !== proc_id_t'(2) || bus.preempt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL slice_%0d: pc=%h cur=%0d pre=%b expected %h 2 0", e, bus.pc, bus.cur_proc, bus.preempt, exp_pc);
                end
            end
        end
        clear_flags();
        vectors++;
        if (bus.pc !== OS_ENTRY || bus.cur_proc !== proc_id_t'(0) || bus.os_mode !== 1'b1 || bus.preempt !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_edge: pc=%h cur=%0d os=%b pre=%b expected %h 0 1 1", bus.pc, bus.cur_proc, bus.os_mode, bus.preempt, OS_ENTRY);
        end
        step();
        if (bus.preempt === 1'b1) pulses++;
        vectors++;
        if (pulses != 1 || bus.pc !== pc_t'(1)) begin
            miscompares++;
            $display("FAIL preempt_once: pulses=%0d pc=%h expected 1 %h", pulses, bus.pc, pc_t'(1));
        end
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(2);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h1A0) || bus.cur_proc !== proc_id_t'(2)) begin
            miscompares++;
            $display("FAIL saved_next_pc: pc=%h cur=%0d expected 1a0 2", bus.pc, bus.cur_proc);
        end
        clear_flags();
    endtask

    task automatic test_swap_on_expiry();
        for (int e = 1; e <= 63; e++) step();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(3);
        step();
        clear_flags();
        vectors++;
        if (bus.pc !== pc_t'(0) || bus.cur_proc !== proc_id_t'(3) || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_on_expiry: pc=%h cur=%0d pre=%b expected 000 3 0", bus.pc, bus.cur_proc, bus.preempt);
        end
        for (int e = 1; e <= 63; e++) begin
            step();
            vectors++;
            if (bus.cur_proc !== proc_id_t'(3) || bus.preempt !== 1'b0 || bus.pc !== pc_t'(e)) begin
                miscompares++;
                $display("FAIL timer_restart_%0d: pc=%h cur=%0d pre=%b expected %h 3 0", e, bus.pc, bus.cur_proc, bus.preempt, pc_t'(e));
            end
        end
        step();
        vectors++;
        if (bus.cur_proc !== proc_id_t'(0) || bus.preempt !== 1'b1 || bus.pc !== OS_ENTRY) begin
            miscompares++;
            $display("FAIL restart_expiry: pc=%h cur=%0d pre=%b expected %h 0 1", bus.pc, bus.cur_proc, bus.preempt, OS_ENTRY);
        end
    endtask

    task automatic test_reset_on_preempt();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(1);
        step();
        clear_flags();
        for (int e = 1; e <= 63; e++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (bus.pc !== BOOT_ADDR || bus.cur_proc !== proc_id_t'(0) || bus.preempt !== 1'b0 || bus.os_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wins: pc=%h cur=%0d pre=%b os=%b expected %h 0 0 1", bus.pc, bus.cur_proc, bus.preempt, bus.os_mode, BOOT_ADDR);
        end
        step();
        vectors++;
        if (bus.preempt !== 1'b0 || bus.pc !== pc_t'(1)) begin
            miscompares++;
            $display("FAIL no_late_pulse: pre=%b pc=%h expected 0 %h", bus.preempt, bus.pc, pc_t'(1));
        end
        for (int p = 1; p <= 4; p++) begin
            bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(p % N_PROC);
            step();
            vectors++;
            if (bus.pc !== pc_t'(0) || bus.cur_proc !== proc_id_t'(p % N_PROC)) begin
                miscompares++;
                $display("FAIL table_cleared_%0d: pc=%h cur=%0d expected 000 %0d", p % N_PROC, bus.pc, bus.cur_proc, p % N_PROC);
            end
        end
        clear_flags();
    endtask

    task automatic test_save_pc();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(3);
        step();
        clear_flags();
        bus.save_proc_pc = 1'b1; bus.jMUX = 1'b1; bus.imm_target = pc_t'(10'h2F0);
        step();
        clear_flags();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(3);
        step();
        vectors++;
        if (bus.pc !== pc_t'(1)) begin
            miscompares++;
            $display("FAIL save_pc: pc=%h expected %h", bus.pc, pc_t'(1));
        end
        clear_flags();
        bus.change_proc_pc = 1'b1; bus.save_proc_pc = 1'b1;
        bus.proc_sel = proc_id_t'(3); bus.reg_data = 32'h0000_0099;
        step();
        clear_flags();
        bus.proc_swap = 1'b1; bus.proc_sel = proc_id_t'(3);
        step();
        vectors++;
        if (bus.pc !== pc_t'(10'h099)) begin
            miscompares++;
            $display("FAIL change_over_save: pc=%h expected %h", bus.pc, pc_t'(10'h099));
        end
        clear_flags();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_priority();
        test_context_swap();
        test_preempt_hlt();
        test_swap_on_expiry();
        test_reset_on_preempt();
        test_save_pc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
